// File: rtl/gb_host.sv
// gb_host: single-master ghostbus host. Accepts one request at a time on a
// valid/ready port, issues a single-cycle write strobe or a fixed-latency
// read on the ghostbus, and reports completion with a one-cycle pulse.
//
// Build option: define GB_HOST_BURST_EN to let reads issue req_len+1 beats
// at incrementing addresses. Without it, every read is a single beat.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a request; req_ready high
// WRITE     | gb_we asserted for exactly this one cycle
// READ_WAIT | address on bus, counting down RD_LAT until gb_din is sampled
// RESP      | rsp_valid pulse; return to IDLE or start the next burst beat
module gb_host #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [7:0]    req_len,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_last,
    output logic          busy,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    output logic          gb_we,
    input  logic [DW-1:0] gb_din
);

`ifdef GB_HOST_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    // Down-counter reload: READ_WAIT lasts RD_LAT cycles, expiring at zero.
    localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [7:0] beats_left;
    logic [7:0] len_eff;
    logic       accept;
    logic       wait_done;
    logic       more_beats;

    // Burst length only matters for reads in the burst build; writes and the
    // single-beat build always see zero extra beats.
    assign len_eff    = (BURST_EN && !req_we) ? req_len : 8'd0;
    assign accept     = req_valid && req_ready;
    assign wait_done  = (wait_cnt == 4'd0);
    assign more_beats = (beats_left != 8'd0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_we ? WRITE : READ_WAIT;
                end
            end
            WRITE: begin
                state_nxt = RESP;
            end
            READ_WAIT: begin
                if (wait_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = more_beats ? READ_WAIT : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; req_ready is held low while reset is applied.
    always_comb begin
        req_ready = (state == IDLE) && !rst;
        busy      = (state != IDLE);
        gb_we     = (state == WRITE);
        rsp_valid = (state == RESP);
        rsp_last  = (state == RESP) && !more_beats;
    end

    // Bus address/data, read capture, latency timer and burst beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gb_addr    <= '0;
            gb_dout    <= '0;
            rsp_rdata  <= '0;
            wait_cnt   <= 4'd0;
            beats_left <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gb_addr    <= req_addr;
                        gb_dout    <= req_wdata;
                        beats_left <= len_eff;
                        wait_cnt   <= WAIT_LOAD;
                    end
                end
                WRITE: begin
                    rsp_rdata <= '0;
                end
                READ_WAIT: begin
                    if (wait_done) begin
                        rsp_rdata <= gb_din;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Next beat starts a fresh full RD_LAT wait at the next
                    // address; the adder wraps naturally at AW bits.
                    if (more_beats) begin
                        gb_addr    <= gb_addr + AW'(1);
                        beats_left <= beats_left - 8'd1;
                        wait_cnt   <= WAIT_LOAD;
                    end
                end
                default: begin
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gb_host.sv
// Testbench for gb_host: directed and randomized transactions checked
// against per-transaction expectations computed from latency arithmetic.
module tb_gb_host;

    localparam int AW     = 24;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;

`ifdef GB_HOST_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [7:0]    req_len = 8'd0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_last;
    logic          busy;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout;
    logic          gb_we;
    logic [DW-1:0] gb_din;

    int n_total = 0;
    int n_pass  = 0;

    gb_host #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_last  (rsp_last),
        .busy      (busy),
        .gb_addr   (gb_addr),
        .gb_dout   (gb_dout),
        .gb_we     (gb_we),
        .gb_din    (gb_din)
    );

    always #5 clk = ~clk;

    // Bus slave model: read data is a fixed function of the address.
    function automatic logic [DW-1:0] din_of(input logic [AW-1:0] a);
        if (a == 24'h000100) return 32'h0000_00cc;
        return (32'(a) * 32'h9e37_79b1) ^ 32'h5a5a_3c3c;
    endfunction

    assign gb_din = din_of(gb_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // One transaction. Expected timing: a beat completes every 'per' cycles
    // after the accept edge (2 for writes, RD_LAT+1 for reads).
    task automatic do_txn(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [7:0] len,
                          input logic hold);
        int beats;
        int per;
        int total;
        int b;
        logic [AW-1:0] a_exp;
        beats = (!we && BURST) ? int'(len) + 1 : 1;
        per   = we ? 2 : RD_LAT + 1;
        total = per * beats;
        @(negedge clk);
        chk("ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_len   = len;
        for (int t = 1; t <= total; t++) begin
            @(negedge clk);
            chk("gb_we", gb_we, (we && t == 1));
            chk("rsp_valid", rsp_valid, (t % per == 0));
            chk("busy", busy, 1);
            chk("ready_busy", req_ready, 0);
            if (we && t == 1) begin
                chk("wr_addr", gb_addr, addr);
                chk("wr_data", gb_dout, wdata);
            end
            if (t % per == 0) begin
                b     = t / per - 1;
                a_exp = addr + AW'(b);
                chk("beat_addr", gb_addr, a_exp);
                chk("rsp_rdata", rsp_rdata, we ? 32'h0 : din_of(a_exp));
                chk("rsp_last", rsp_last, (b == beats - 1));
            end
            // Ignored traffic while busy: garbage or nothing.
            req_valid = hold;
            req_we    = $urandom_range(0, 1);
            req_addr  = AW'($urandom);
            req_wdata = $urandom;
            req_len   = 8'($urandom);
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_ready", req_ready, 1);
        chk("idle_rsp", rsp_valid, 0);
        chk("idle_addr_hold", gb_addr, addr + AW'(beats - 1));
        chk("idle_rdata_hold", rsp_rdata, we ? 32'h0 : din_of(addr + AW'(beats - 1)));
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", gb_addr, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", req_ready, 1);

        // Directed write and read.
        do_txn(1'b1, 24'h000001, 32'hceceface, 8'd5, 1'b0);
        do_txn(1'b0, 24'h000100, 32'h0, 8'd0, 1'b0);
        // Busy: req_valid held high through a read.
        do_txn(1'b0, 24'h000100, 32'h0, 8'd0, 1'b1);
        // Burst with address wrap (single beat without the burst build).
        do_txn(1'b0, 24'hFFFFFE, 32'h0, 8'd3, 1'b0);
        // Write ignores req_len.
        do_txn(1'b1, 24'hFFFFFF, 32'h1234_5678, 8'd3, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 25; i++) begin
            do_txn(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? AW'(24'hFFFFFC + $urandom_range(0, 3)) : AW'($urandom),
                   $urandom, 8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset during READ_WAIT: abort with no response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000100; req_len = 8'd2;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rw_state_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_ready", req_ready, 0);
        chk("ar_rsp", rsp_valid, 0);
        chk("ar_last", rsp_last, 0);
        chk("ar_addr", gb_addr, 0);
        chk("ar_dout", gb_dout, 0);
        chk("ar_rdata", rsp_rdata, 0);
        chk("ar_we", gb_we, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ar_hold_rsp", rsp_valid, 0);
            chk("ar_hold_ready", req_ready, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ar_rel_ready", req_ready, 1);
        chk("ar_rel_rsp", rsp_valid, 0);

        // Reset during WRITE: strobe drops asynchronously.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h000042; req_wdata = 32'hdead_beef;
        @(negedge clk);
        req_valid = 1'b0;
        chk("aw_we_before", gb_we, 1);
        rst = 1'b1;
        #1;
        chk("aw_we_drop", gb_we, 0);
        chk("aw_dout", gb_dout, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("aw_no_rsp", rsp_valid, 0);
        end
        chk("aw_ready", req_ready, 1);

        // Normal operation after reset.
        do_txn(1'b0, 24'h000100, 32'h0, 8'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gb_host.md
GB_HOST -- requirements
Module: gb_host

Interface
REQ-001 SHALL have parameter AW, default 24: ghostbus address width.
REQ-002 SHALL have parameter DW, default 32: ghostbus data width.
REQ-003 SHALL have parameter RD_LAT, default 2, legal range 1..15: cycles from gb_addr valid to the gb_din sample edge.
REQ-004 SHALL have port clk, input, 1 bit: single clock; the ghostbus runs on this clock. One clock; reset is asynchronous and active-high.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit: request offered.
REQ-007 SHALL have port req_ready, output, 1 bit: request accepted when high with req_valid.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, AW bits: start address.
REQ-010 SHALL have port req_wdata, input, DW bits: write data.
REQ-011 SHALL have port req_len, input, 8 bits: read burst beats minus 1.
REQ-012 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, DW bits: read data; zero for write completions.
REQ-014 SHALL have port rsp_last, output, 1 bit: final beat of a transaction.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 SHALL have port gb_addr, output, AW bits: bus address.
REQ-017 SHALL have port gb_dout, output, DW bits: bus write data.
REQ-018 SHALL have port gb_we, output, 1 bit: bus write strobe.
REQ-019 SHALL have port gb_din, input, DW bits: bus read data.

Function
REQ-020 SHALL implement states IDLE, WRITE, READ_WAIT, RESP; req_ready SHALL equal (state==IDLE).
REQ-021 On req_valid&req_ready, SHALL register req_addr onto gb_addr, req_wdata onto gb_dout and req_len internally, then go to WRITE if req_we else READ_WAIT.
REQ-022 WRITE SHALL last exactly one cycle with gb_we=1; then go to RESP.
REQ-023 gb_we SHALL be high only in WRITE; never two consecutive cycles.
REQ-024 READ_WAIT SHALL hold gb_we=0 and count RD_LAT cycles from gb_addr update; at expiry SHALL capture gb_din into rsp_rdata and go to RESP.
REQ-025 RESP SHALL last one cycle with rsp_valid=1; rsp_last=1 on final beat; then go to IDLE, or back to READ_WAIT for the next burst beat.
REQ-026 Single read latency, accept to rsp_valid: RD_LAT+1 cycles; write: 2 cycles.
REQ-027 rsp_valid SHALL have no backpressure; consumer must accept every pulse.
REQ-028 gb_addr and gb_dout SHALL hold their last values in IDLE.
REQ-029 req_valid while busy SHALL be ignored, not queued; inputs outside the accept cycle SHALL be ignored.
REQ-030 rsp_rdata SHALL hold its value until the next RESP.

Reset
REQ-031 rst high SHALL force immediately: state=IDLE, gb_we=0, gb_addr=0, gb_dout=0, rsp_valid=0, rsp_rdata=0, rsp_last=0, busy=0, counters=0.
REQ-032 req_ready SHALL be 0 while rst is high and 1 in the first cycle after deassertion.
REQ-033 Reset mid-transaction SHALL abort it with no rsp_valid pulse; gb_we SHALL drop asynchronously.

Configuration
REQ-034 With macro GB_HOST_BURST_EN defined, a read SHALL issue req_len+1 beats: gb_addr increments by 1 (modulo 2^AW, wrapping from all-ones to 0) after each RESP, each beat waits the full RD_LAT, and rsp_last=1 only on the final beat.
REQ-035 Without GB_HOST_BURST_EN, req_len SHALL be ignored, every read SHALL be one beat, and rsp_last SHALL equal rsp_valid.
REQ-036 Writes SHALL always be single-beat; req_len SHALL be ignored for writes in both configurations.

Verification
REQ-037 Write test: write addr 0x000001, data 0xceceface -> gb_we high exactly one cycle with those values; rsp_valid and rsp_last 2 cycles after accept; rsp_rdata=0.
REQ-038 Read test: read 0x000100 with the model returning 0xcc after RD_LAT=2 -> rsp_rdata=0x000000cc 3 cycles after accept; gb_we stays 0.
REQ-039 Busy test: hold req_valid high through a read -> exactly one transaction per IDLE visit; req_ready=0 while busy=1.
REQ-040 Burst test (GB_HOST_BURST_EN): read addr 0xFFFFFE, req_len=3 -> gb_addr sequence FFFFFE, FFFFFF, 000000, 000001; 4 rsp_valid pulses; rsp_last on the 4th only.
REQ-041 No-burst test (no macro): same stimulus as REQ-040 -> one beat; rsp_last=1 on it.
REQ-042 Reset test: assert rst during READ_WAIT -> no rsp_valid; all outputs zero; req_ready=1 in the first cycle after release.
